// File: rtl/product_accumulator_pkg.sv
// product_accumulator_pkg: shared state encoding and default datapath widths for the MAC lab chain
package product_accumulator_pkg;
  typedef enum logic {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_t;
  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF = 10;
endpackage

// File: rtl/product_accumulator.sv
// product_accumulator: sums COUNT consecutive products per group and presents each group sum via valid/ready
// Ports: clk, rst_n (sync active-low), clear (sync abort of partial group and pending result)
//        in_valid/in_ready/p    : product input handshake
//        out_valid/out_ready    : result output handshake
//        sum/overflow           : group sum modulo 2^ACC_W, and whether any carry left ACC_W during the group
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int COUNT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  sum,
  output logic              overflow
);
  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  state_t state, state_next;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0] cnt;
  logic ovf_acc;
  logic [ACC_W:0] total;
  logic take, last;
  // one extra bit so the carry out of the accumulator is visible
  assign total = {1'b0, acc} + (ACC_W + 1)'(p);
  assign in_ready = (state == ST_ACCUM);
  assign out_valid = (state == ST_HOLD);
  assign take = in_valid && in_ready;
  assign last = (cnt == CW'(COUNT - 1));
  always_comb begin
    state_next = state;
    if (clear) state_next = ST_ACCUM;
    else if (take && last) state_next = ST_HOLD;
    else if (out_valid && out_ready) state_next = ST_ACCUM;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_ACCUM;
    else state <= state_next;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf_acc <= 1'b0;
      sum <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
      ovf_acc <= 1'b0;
    end else if (take && last) begin
      sum <= total[ACC_W-1:0];
      overflow <= ovf_acc | total[ACC_W];
      acc <= '0;
      cnt <= '0;
      ovf_acc <= 1'b0;
    end else if (take) begin
      acc <= total[ACC_W-1:0];
      cnt <= cnt + CW'(1);
      ovf_acc <= ovf_acc | total[ACC_W];
    end
  end
endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
Downstream consumer of the 4-bit array multiplier's 8-bit product.
- Accepts one product per valid/ready handshake.
- Sums COUNT consecutive products (a dot-product group) into a registered accumulator.
- Presents the group sum with a valid/ready output handshake.
- Turns the combinational multiplier into the first sequential MAC datapath of the lab chain.

Parameters:
PROD_W, 8, width of incoming product (matches 4x4 multiplier output)
ACC_W, 10, accumulator/sum width; default holds 4*225=900 without overflow
COUNT, 4, products per group; legal range 1..16

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
clear  input  1  synchronous abort: discard partial group and any pending result
in_valid  input  1  product on p is valid
in_ready  output  1  block can accept a product this cycle
p  input  PROD_W  unsigned product from multiplier
out_valid  output  1  sum/overflow hold a completed group result
out_ready  input  1  downstream accepts result
sum  output  ACC_W  completed group sum, modulo 2^ACC_W
overflow  output  1  a carry out of ACC_W occurred during this group

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n); no asynchronous logic.
- Reset (rst_n=0 at a clk edge):
  - state=ACCUM; acc=0; cnt=0.
  - sum=0, out_valid=0, overflow=0.
  - Reset overrides clear and all handshakes.
- States: ACCUM, HOLD. Encoding is 1 bit.
- in_ready = (state==ACCUM), combinational from the state register only. It does not depend on in_valid or out_ready.
- ACCUM, accept (in_valid && in_ready):
  - acc_next = acc + p, computed ACC_W+1 wide.
  - ovf_acc |= carry bit.
  - cnt increments.
- ACCUM, in_valid=0: acc, cnt and ovf_acc hold.
- Final product (accept while cnt==COUNT-1):
  - sum <= low ACC_W bits of acc+p.
  - overflow <= ovf_acc | carry.
  - out_valid <= 1; state -> HOLD.
  - acc, cnt, ovf_acc cleared.
  - Latency: result visible the cycle after the final accept.
- HOLD:
  - in_ready=0; sum, overflow and out_valid stable until out_ready=1.
  - On out_valid && out_ready: out_valid <= 0; state -> ACCUM.
  - in_ready returns the following cycle. No accept can occur in the same cycle as the output handshake, so throughput is COUNT+1 cycles per group at best.
- COUNT=1: every accept goes directly to HOLD.
- clear=1 (rst_n=1):
  - state -> ACCUM; acc=0; cnt=0; ovf_acc=0; out_valid=0.
  - sum and overflow keep their last values, which are ignored while out_valid=0.
  - An in_valid product in the same cycle is dropped, even though in_ready was 1.
  - clear has priority over both handshakes.
- Wrap-around: the accumulator is modulo 2^ACC_W; the overflow flag is sticky per group only.
- p is treated as unsigned. No X propagation is permitted from p when in_valid=0.
- cnt width is $clog2(COUNT) with a minimum of 1. It wraps only through the group-complete path.

Decomposition:
- Shared package holds:
  - state encoding constants ST_ACCUM=1'b0, ST_HOLD=1'b1;
  - default widths PROD_W=8 and ACC_W=10, so the multiplier bench, this block and the future MAC top agree.
- No sub-module is required.
- The group counter may be split into a small reusable mod_counter (enable, sync clear, terminal-count output) if the team wants it for later labs; otherwise it stays inline.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with in_valid=1, p=8'd50 -> out_valid=0, sum=0, overflow=0; in_ready=1 after release; first group unaffected by products seen during reset.
2. Basic group: feed p=9, 20, 36, 225 back-to-back (COUNT=4), out_ready=1 -> out_valid=1 the cycle after the 4th accept, sum=290, overflow=0; in_ready=0 that cycle, =1 the next.
3. Backpressure: complete group p=1, 2, 3, 4 with out_ready=0 for 5 cycles and in_valid held high with p=7 -> sum=10 held stable, in_ready=0 throughout, no product absorbed; after out_ready=1, next group starts with 7.
4. Overflow: ACC_W=8 override, feed 225, 225, 1, 0 -> sum=(451 mod 256)=195, overflow=1; next group 1, 1, 1, 1 -> sum=4, overflow=0.
5. clear mid-group: accept 100, 100, then clear=1 with in_valid=1, p=50 -> partial discarded and the 50 dropped; following 10, 10, 10, 10 -> sum=40.
6. Exhaustive stream: drive all 256 a/b pairs through Multiplier_4bit into the block with random in_valid/out_ready gaps -> each sum equals the scoreboard sum of its four products; 64 results, none lost or duplicated.
